// File: rtl/lct_l1a_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// lct_l1a_gen
//
// Calibration / self-test sequencer for the LCT delay/match path on the DMB
// control FPGA. One START launches a burst of LCT pulses. Each LCT is followed
// by an L1A at a programmed LCT-to-L1A spacing, and consecutive pairs are
// separated by a programmed idle gap. L1A_MATCH pulses coming back from the
// match path are counted, so a timing scan can confirm the latency and
// fine-delay settings from inside the chip.
//
// Burst timing (cycle numbers relative to the cycle in which START is taken):
//   LCT  k : 1 + k*(DLY+SPACING+1),  k = 0 .. N-1
//   L1A  k : LCT k + DLY             (suppressed when EN_L1A = 0)
//   DONE   : final L1A slot + 1      (BUSY already low in that cycle)
//
// Ports
//   CLK          in   1  system clock, all logic on the rising edge
//   RST          in   1  synchronous active-high reset
//   START        in   1  one-cycle burst request, acted on only in IDLE
//   NPULSE       in   8  LCT/L1A pairs per burst, 0 means 256
//   LCT_L1A_DLY  in   8  cycles from each LCT to its L1A (0..255)
//   SPACING      in   8  idle cycles between an L1A slot and the next LCT
//   EN_L1A       in   1  1 = issue L1A after each LCT, 0 = LCT only
//   L1A_MATCH    in   1  match pulse returned by the delay/match path
//   LCT          out  1  one-cycle LCT pulse
//   L1A          out  1  one-cycle L1A pulse
//   BUSY         out  1  high from the first LCT through the final L1A slot
//   DONE         out  1  one-cycle pulse when a burst completes
//   PCNT         out  9  LCTs issued in the current or last burst
//   MATCH_CNT    out  8  L1A_MATCH pulses since the last accepted START,
//                        saturating at 255
//
// All outputs are registered. Every transition that enters a state also sets
// that state's outputs, so a pulse appears in the same cycle the FSM sits in
// the corresponding state.
// -----------------------------------------------------------------------------
module lct_l1a_gen (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [7:0] NPULSE,
    input  logic [7:0] LCT_L1A_DLY,
    input  logic [7:0] SPACING,
    input  logic       EN_L1A,
    input  logic       L1A_MATCH,
    output logic       LCT,
    output logic       L1A,
    output logic       BUSY,
    output logic       DONE,
    output logic [8:0] PCNT,
    output logic [7:0] MATCH_CNT
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LCT,
        S_WAIT,
        S_L1A,
        S_GAP,
        S_FIN
    } state_t;

    state_t     state;

    // Burst configuration captured when START is accepted; later input
    // changes do not disturb a running burst.
    logic [8:0] npulse_q;
    logic [7:0] dly_q;
    logic [7:0] spacing_q;
    logic       en_l1a_q;

    // Remaining WAIT / GAP cycles. Both are loaded only on state entry and
    // the state is left on the cycle they count down to zero, so they never
    // wrap below zero.
    logic [7:0] dly_cnt;
    logic [7:0] gap_cnt;

    logic       start_accept;
    logic       last_pulse;

    assign start_accept = (state == S_IDLE) && START;

    // PCNT already includes the LCT of the pair now finishing.
    assign last_pulse   = (PCNT == npulse_q);

    // -------------------------------------------------------------------------
    // Burst sequencer
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            npulse_q  <= 9'd0;
            dly_q     <= 8'd0;
            spacing_q <= 8'd0;
            en_l1a_q  <= 1'b0;
            dly_cnt   <= 8'd0;
            gap_cnt   <= 8'd0;
            LCT       <= 1'b0;
            L1A       <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            PCNT      <= 9'd0;
        end else begin
            // Single-cycle pulses drop unless the arm below re-asserts them.
            LCT  <= 1'b0;
            L1A  <= 1'b0;
            DONE <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (START) begin
                        npulse_q  <= (NPULSE == 8'd0) ? 9'd256 : {1'b0, NPULSE};
                        dly_q     <= LCT_L1A_DLY;
                        spacing_q <= SPACING;
                        en_l1a_q  <= EN_L1A;
                        // First LCT: PCNT is cleared and counts this LCT.
                        // The config registers are not loaded yet, so the
                        // zero-delay L1A decision uses the live inputs.
                        state     <= S_LCT;
                        LCT       <= 1'b1;
                        L1A       <= (LCT_L1A_DLY == 8'd0) && EN_L1A;
                        BUSY      <= 1'b1;
                        PCNT      <= 9'd1;
                    end
                end

                S_LCT: begin
                    if (dly_q == 8'd0) begin
                        // The L1A slot coincided with this LCT, so the pair
                        // is already complete.
                        if (last_pulse) begin
                            state <= S_FIN;
                            DONE  <= 1'b1;
                            BUSY  <= 1'b0;
                        end else if (spacing_q == 8'd0) begin
                            state <= S_LCT;
                            LCT   <= 1'b1;
                            L1A   <= en_l1a_q;
                            PCNT  <= PCNT + 9'd1;
                        end else begin
                            state   <= S_GAP;
                            gap_cnt <= spacing_q;
                        end
                    end else if (dly_q == 8'd1) begin
                        // DLY-1 = 0 WAIT cycles: the L1A slot is the next cycle.
                        state <= S_L1A;
                        L1A   <= en_l1a_q;
                    end else begin
                        state   <= S_WAIT;
                        dly_cnt <= dly_q - 8'd1;
                    end
                end

                S_WAIT: begin
                    dly_cnt <= dly_cnt - 8'd1;
                    if (dly_cnt == 8'd1) begin
                        state <= S_L1A;
                        L1A   <= en_l1a_q;
                    end
                end

                S_L1A: begin
                    if (last_pulse) begin
                        state <= S_FIN;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                    end else if (spacing_q == 8'd0) begin
                        state <= S_LCT;
                        LCT   <= 1'b1;
                        L1A   <= (dly_q == 8'd0) && en_l1a_q;
                        PCNT  <= PCNT + 9'd1;
                    end else begin
                        state   <= S_GAP;
                        gap_cnt <= spacing_q;
                    end
                end

                S_GAP: begin
                    gap_cnt <= gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1) begin
                        state <= S_LCT;
                        LCT   <= 1'b1;
                        L1A   <= (dly_q == 8'd0) && en_l1a_q;
                        PCNT  <= PCNT + 9'd1;
                    end
                end

                S_FIN: begin
                    // DONE is showing this cycle; a START here is ignored.
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Match counter
    //
    // Runs in every state because matches can arrive after DONE. An accepted
    // START clears the count and outranks a simultaneous match.
    // -------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            MATCH_CNT <= 8'd0;
        end else if (start_accept) begin
            MATCH_CNT <= 8'd0;
        end else if (L1A_MATCH && (MATCH_CNT != 8'hFF)) begin
            MATCH_CNT <= MATCH_CNT + 8'd1;
        end
    end

endmodule

// File: doc/lct_l1a_gen.md
# lct_l1a_gen

Calibration/self-test sequencer that issues bursts of LCT pulses, each followed by an L1A at a programmed LCT-to-L1A spacing, and counts the resulting L1A_MATCH pulses. It drives the DIN/L1A inputs of the LCT delay/match path on the DMB control FPGA, so a timing scan can confirm the latency and fine-delay settings from inside the chip. It also counts L1A_MATCH returned by that path.

## Interface
Parameters: none.

Ports:
- CLK  in  1  system clock; all logic on the rising edge
- RST  in  1  reset; synchronous, active-high
- START  in  1  one-cycle request to start a burst; only acted on in IDLE
- NPULSE  in  8  LCT/L1A pairs per burst; 0 means 256
- LCT_L1A_DLY  in  8  cycles from each LCT to its L1A (0..255)
- SPACING  in  8  idle cycles between an L1A and the next LCT (0..255)
- EN_L1A  in  1  1 = issue L1A after each LCT; 0 = LCT only, with the same timing
- L1A_MATCH  in  1  match pulse returned by the delay/match path
- LCT  out  1  one-cycle LCT pulse
- L1A  out  1  one-cycle L1A pulse
- BUSY  out  1  high from the first LCT cycle through the final L1A slot
- DONE  out  1  one-cycle pulse when a burst ends
- PCNT  out  9  LCTs issued in the current or last burst
- MATCH_CNT  out  8  L1A_MATCH pulses since the last accepted START; saturates at 255

## Operation
- FSM states: IDLE, LCT, WAIT, L1A, GAP, FIN.
- IDLE:
  - If START=1, move to LCT.
  - Latch NPULSE (0 loaded as 256), LCT_L1A_DLY, SPACING and EN_L1A into internal registers.
  - Clear PCNT and MATCH_CNT.
  - Input changes after this point have no effect until the next burst.
- LCT:
  - Assert LCT and increment PCNT.
  - If latched DLY=0: the L1A slot is this same cycle (L1A=EN_L1A), and the next state is GAP or FIN.
  - If latched DLY>0: load the delay counter with DLY-1 and go to WAIT.
- WAIT: decrement the delay counter; move to L1A when it reaches 0.
- L1A:
  - Assert L1A if EN_L1A=1.
  - If PCNT equals the latched count, go to FIN.
  - Otherwise load the gap counter with SPACING and go to GAP; if SPACING=0, go straight to LCT.
- GAP: decrement the gap counter; move to LCT on the cycle it reaches 0.
- FIN: pulse DONE, drop BUSY, return to IDLE.
- START is ignored in every state except IDLE. A START in the FIN cycle is also ignored.
- MATCH_CNT counts L1A_MATCH in any state, including after DONE, because matches arrive late.
  - It holds at 255.
  - An accepted START in the same cycle as L1A_MATCH clears the count (clear wins; that match is not counted).
- RST:
  - Forces IDLE and clears the delay and gap counters.
  - Takes effect from the cycle after the RST edge, including in the middle of a burst: no further LCT or L1A, and no DONE for the aborted burst.

## Timing
- Reset values: LCT=0, L1A=0, BUSY=0, DONE=0, PCNT=0, MATCH_CNT=0.
- All outputs are registered.
- START high at edge T gives LCT high in cycle T+1; BUSY rises with that first LCT.
- Each L1A comes exactly LCT_L1A_DLY cycles after its LCT.
- The next LCT comes SPACING+1 cycles after the previous L1A slot.
- Pulse period is DLY+SPACING+1 cycles.
- DONE is high in the cycle after the final L1A slot. BUSY is low in that same cycle.
- The next START can be accepted in the cycle after DONE.
- PCNT is the 9-bit LCT count (up to 256). The delay and gap counters are 8 bits and never wrap: both are loaded only at state entry.

## Test plan
- Basic timing:
  - Stimulus: NPULSE=3, DLY=5, SPACING=2, EN_L1A=1, START at cycle 0.
  - Required: LCT at 1, 9, 17; L1A at 6, 14, 22; DONE at 23; PCNT=3; BUSY high for cycles 1..22.
- Zero delay and zero spacing:
  - Stimulus: NPULSE=4, DLY=0, SPACING=0.
  - Required: LCT and L1A coincide at cycles 1, 2, 3, 4; DONE at 5.
- Wrap case:
  - Stimulus: NPULSE=0, DLY=1, SPACING=0.
  - Required: 256 LCTs with period 2; PCNT=256 at DONE; a START during the burst is ignored and does not clear the counts.
- Loop-back:
  - Stimulus: LCT/L1A looped into the delay/match path with matching latency, NPULSE=10.
  - Required: MATCH_CNT=10 after DONE plus the path latency.
  - Stimulus: drive 300 L1A_MATCH pulses. Required: MATCH_CNT holds at 255.
- Reset mid-burst:
  - Stimulus: RST asserted during WAIT of pulse 2.
  - Required: all outputs 0 the next cycle; no DONE for the aborted burst; a START one cycle after RST deasserts runs a full burst normally.
- EN_L1A=0 and simultaneous clear:
  - Stimulus: burst with EN_L1A=0. Required: LCT timing unchanged and no L1A.
  - Stimulus: START and L1A_MATCH in the same cycle. Required: MATCH_CNT=0.
